// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request and write-back bundle for muldiv_unit
//
// Purpose: carries the operand request from the issuing side and the
// write-back/status signals returned by the multiply/divide unit.
// Ports (signals):
//   start, op, src_a, src_b, dest   request (master -> slave)
//   busy, done, hi                  status / high half or remainder (slave -> master)
//   wb_we, wb_reg, wb_data          reg_file write port (slave -> master)
// Modports: master = issuing side / bench, slave = muldiv_unit.

interface muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       dest;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic             wb_we;
  logic [1:0]       wb_reg;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output start, op, src_a, src_b, dest,
    input  busy, done, hi, wb_we, wb_reg, wb_data
  );

  modport slave (
    input  start, op, src_a, src_b, dest,
    output busy, done, hi, wb_we, wb_reg, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide execute unit
//
// Purpose: shift-add multiply (and, with MULDIV_DIV_EN defined, restoring
// divide) over WIDTH cycles, writing the low half / quotient back to the
// reg_file with a one-cycle pulse and holding the high half / remainder in hi.
// Ports:
//   clock    system clock, all state changes on posedge
//   reset_n  synchronous active-low reset
//   bus      muldiv_unit_if.slave: start/op/src_a/src_b/dest request,
//            busy/done/hi status, wb_we/wb_reg/wb_data write-back
// Configuration: MULDIV_DIV_EN enables the divider; without it op=1 completes
// on the next edge with no write-back and unchanged results.

module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input logic          clock,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [4:0]       count;
  logic [WIDTH-1:0] a_q;       // multiplicand / dividend
  logic [WIDTH-1:0] work_hi;   // running high half / partial remainder
  logic [WIDTH-1:0] work_lo;   // multiplier being consumed / quotient being built
  logic             busy_q;
  logic             done_q;
  logic             wb_we_q;
  logic [1:0]       wb_reg_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [WIDTH-1:0] hi_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

`ifdef MULDIV_DIV_EN
  logic             op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
`endif

  // One iteration of the selected algorithm, applied to the work registers.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q) begin
      // Borrow out of the top bit means the trial subtract went negative.
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= 5'd0;
      a_q       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_reg_q  <= 2'b00;
      wb_data_q <= '0;
      hi_q      <= '0;
`ifdef MULDIV_DIV_EN
      op_q      <= 1'b0;
      b_q       <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      wb_we_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q      <= bus.src_a;
            wb_reg_q <= bus.dest;
            count    <= 5'(WIDTH);
            work_hi  <= '0;
`ifdef MULDIV_DIV_EN
            op_q     <= bus.op;
            b_q      <= bus.src_b;
            // Dividend enters the quotient register and is shifted out MSB first.
            work_lo  <= bus.op ? bus.src_a : bus.src_b;
            state    <= RUN;
            busy_q   <= 1'b1;
`else
            work_lo  <= bus.src_b;
            if (bus.op) begin
              // No divider built: complete immediately, results untouched.
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
`endif
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        RUN: begin
          count   <= count - 5'd1;
          work_hi <= step_hi;
          work_lo <= step_lo;
`ifdef MULDIV_DIV_EN
          if (op_q && (b_q == '0)) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            wb_we_q   <= (wb_reg_q != 2'b00);
            wb_data_q <= '1;
            hi_q      <= a_q;
          end else
`endif
          if (count == 5'd1) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            wb_we_q   <= (wb_reg_q != 2'b00);   // R0 is hard-wired to zero
            wb_data_q <= step_lo;
            hi_q      <= step_hi;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wb_we   = wb_we_q;
  assign bus.wb_reg  = wb_reg_q;
  assign bus.wb_data = wb_data_q;
  assign bus.hi      = hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [1:0] d);
    @(negedge clock);
    bus.op = o; bus.src_a = a; bus.src_b = b; bus.dest = d; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Returns the cycle (1 = first negedge after the capture edge) where done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.dest = 2'b00;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL reset_wb_we got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.wb_reg !== 2'b00) $display("FAIL reset_wb_reg got %b want 00", bus.wb_reg); else passed++;
    total++; if (bus.wb_data !== 16'h0000) $display("FAIL reset_wb_data got %h want 0000", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0000) $display("FAIL reset_hi got %h want 0000", bus.hi); else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_mul_basic;
    int lat;
    issue(1'b0, 16'd3, 16'd5, 2'd1);
    total++; if (bus.busy !== 1'b1) $display("FAIL mul_busy got %b want 1", bus.busy); else passed++;
    wait_done(lat);
    total++; if (lat != 17) $display("FAIL mul_latency got %0d want 17", lat); else passed++;
    total++; if (bus.wb_data !== 16'h000F) $display("FAIL mul3x5_lo got %h want 000f", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0000) $display("FAIL mul3x5_hi got %h want 0000", bus.hi); else passed++;
    total++; if (bus.wb_we !== 1'b1) $display("FAIL mul3x5_we got %b want 1", bus.wb_we); else passed++;
    total++; if (bus.wb_reg !== 2'd1) $display("FAIL mul3x5_reg got %0d want 1", bus.wb_reg); else passed++;
    @(negedge clock);
    total++; if (bus.done !== 1'b0) $display("FAIL done_pulse got %b want 0", bus.done); else passed++;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL we_pulse got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.wb_data !== 16'h000F) $display("FAIL result_hold got %h want 000f", bus.wb_data); else passed++;
  endtask

  task automatic test_mul_patterns;
    int lat;
    issue(1'b0, 16'hFFFF, 16'hFFFF, 2'd2);
    wait_done(lat);
    total++; if (bus.wb_data !== 16'h0001) $display("FAIL mulmax_lo got %h want 0001", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'hFFFE) $display("FAIL mulmax_hi got %h want fffe", bus.hi); else passed++;
    total++; if (bus.wb_reg !== 2'd2) $display("FAIL mulmax_reg got %0d want 2", bus.wb_reg); else passed++;
    issue(1'b0, 16'h1234, 16'h5678, 2'd3);
    wait_done(lat);
    total++; if (bus.wb_data !== 16'h0060) $display("FAIL mulmix_lo got %h want 0060", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0626) $display("FAIL mulmix_hi got %h want 0626", bus.hi); else passed++;
  endtask

  task automatic test_div;
    int lat;
`ifdef MULDIV_DIV_EN
    issue(1'b1, 16'd100, 16'd7, 2'd3);
    wait_done(lat);
    total++; if (lat != 17) $display("FAIL div_latency got %0d want 17", lat); else passed++;
    total++; if (bus.wb_data !== 16'h000E) $display("FAIL div_quot got %h want 000e", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0002) $display("FAIL div_rem got %h want 0002", bus.hi); else passed++;
    total++; if (bus.wb_we !== 1'b1) $display("FAIL div_we got %b want 1", bus.wb_we); else passed++;
    issue(1'b1, 16'h1234, 16'h0000, 2'd3);
    wait_done(lat);
    total++; if (lat != 2) $display("FAIL div0_latency got %0d want 2", lat); else passed++;
    total++; if (bus.wb_data !== 16'hFFFF) $display("FAIL div0_quot got %h want ffff", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h1234) $display("FAIL div0_rem got %h want 1234", bus.hi); else passed++;
    issue(1'b1, 16'hFFFF, 16'h0001, 2'd2);
    wait_done(lat);
    total++; if (bus.wb_data !== 16'hFFFF) $display("FAIL div1_quot got %h want ffff", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0000) $display("FAIL div1_rem got %h want 0000", bus.hi); else passed++;
`else
    issue(1'b0, 16'd6, 16'd7, 2'd1);
    wait_done(lat);
    issue(1'b1, 16'h1234, 16'h0003, 2'd2);
    wait_done(lat);
    total++; if (lat != 1) $display("FAIL nodiv_latency got %0d want 1", lat); else passed++;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL nodiv_we got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.wb_data !== 16'h002A) $display("FAIL nodiv_lo got %h want 002a", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0000) $display("FAIL nodiv_hi got %h want 0000", bus.hi); else passed++;
`endif
  endtask

  task automatic test_ignore_start;
    int ndone = 0;
    int dlat = 0;
    logic [15:0] data = '0;
    issue(1'b0, 16'd2, 16'd2, 2'd1);
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin dlat = c; data = bus.wb_data; end
      end
      bus.start = (c == 5);
      if (c == 5) begin bus.src_a = 16'd9; bus.src_b = 16'd9; end
      @(negedge clock);
    end
    bus.start = 1'b0;
    total++; if (ndone != 1) $display("FAIL ignore_done_count got %0d want 1", ndone); else passed++;
    total++; if (dlat != 17) $display("FAIL ignore_latency got %0d want 17", dlat); else passed++;
    total++; if (data !== 16'h0004) $display("FAIL ignore_result got %h want 0004", data); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1'b0, 16'd2, 16'd3, 2'd1);
    wait_done(lat);
    total++; if (bus.wb_data !== 16'h0006) $display("FAIL b2b_first got %h want 0006", bus.wb_data); else passed++;
    bus.op = 1'b0; bus.src_a = 16'd4; bus.src_b = 16'd5; bus.dest = 2'd2; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL b2b_done got %b want 0", bus.done); else passed++;
    wait_done(lat);
    total++; if (lat != 17) $display("FAIL b2b_latency got %0d want 17", lat); else passed++;
    total++; if (bus.wb_data !== 16'h0014) $display("FAIL b2b_second got %h want 0014", bus.wb_data); else passed++;
    total++; if (bus.wb_reg !== 2'd2) $display("FAIL b2b_reg got %0d want 2", bus.wb_reg); else passed++;
  endtask

  task automatic test_dest_zero;
    int lat;
    issue(1'b0, 16'd6, 16'd7, 2'd0);
    wait_done(lat);
    total++; if (bus.done !== 1'b1) $display("FAIL r0_done got %b want 1", bus.done); else passed++;
    total++; if (bus.wb_data !== 16'h002A) $display("FAIL r0_data got %h want 002a", bus.wb_data); else passed++;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL r0_we got %b want 0", bus.wb_we); else passed++;
  endtask

  task automatic test_reset_midop;
    int ndone = 0;
    issue(1'b0, 16'h0100, 16'h0100, 2'd3);
    repeat (6) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else passed++;
    total++; if (bus.wb_we !== 1'b0) $display("FAIL abort_we got %b want 0", bus.wb_we); else passed++;
    total++; if (bus.wb_data !== 16'h0000) $display("FAIL abort_data got %h want 0000", bus.wb_data); else passed++;
    total++; if (bus.hi !== 16'h0000) $display("FAIL abort_hi got %h want 0000", bus.hi); else passed++;
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clock);
    end
    total++; if (ndone != 0) $display("FAIL abort_no_done got %0d want 0", ndone); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_patterns();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_dest_zero();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
